// File: rtl/qam_pkg.sv
// Shared types and constants for the 16-QAM modulator: levels, Gray map,
// FSM states and sine-table geometry.
package qam_pkg;

  typedef logic signed [3:0] level_t;

  localparam level_t LVL_M2   = -4'sd2;
  localparam level_t LVL_M1   = -4'sd1;
  localparam level_t LVL_P1   = 4'sd1;
  localparam level_t LVL_P2   = 4'sd2;
  localparam level_t LVL_ZERO = 4'sd0;

  localparam logic [1:0] GRAY_M2 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P2 = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int SIN_AMP   = 32767;
  localparam int LUT_DEPTH = 256;
  localparam int LUT_AW    = 8;
  localparam int LUT_DW    = 16;

  function automatic level_t gray_map(input logic [1:0] b);
    level_t lvl;
    case (b)
      GRAY_M2: lvl = LVL_M2;
      GRAY_M1: lvl = LVL_M1;
      GRAY_P1: lvl = LVL_P1;
      default: lvl = LVL_P2;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam_sin_lut.sv
// 256-entry signed sine ROM (amplitude 32767) with registered sin and cos
// read ports; built from a 65-entry quarter-wave table.
module qam_sin_lut
  import qam_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LUT_AW-1:0]        sin_addr,
  input  logic [LUT_AW-1:0]        cos_addr,
  output logic signed [LUT_DW-1:0] sin_q,
  output logic signed [LUT_DW-1:0] cos_q
);

  logic signed [LUT_DW-1:0] sin_d;
  logic signed [LUT_DW-1:0] cos_d;

  // round(32767 * sin(k*pi/128)) for k = 0..64
  function automatic logic signed [LUT_DW-1:0] quarter(input logic [6:0] k);
    logic signed [LUT_DW-1:0] v;
    case (k)
      7'd0:  v = 16'sd0;     7'd1:  v = 16'sd804;   7'd2:  v = 16'sd1608;  7'd3:  v = 16'sd2410;
      7'd4:  v = 16'sd3212;  7'd5:  v = 16'sd4011;  7'd6:  v = 16'sd4808;  7'd7:  v = 16'sd5602;
      7'd8:  v = 16'sd6393;  7'd9:  v = 16'sd7179;  7'd10: v = 16'sd7962;  7'd11: v = 16'sd8739;
      7'd12: v = 16'sd9512;  7'd13: v = 16'sd10278; 7'd14: v = 16'sd11039; 7'd15: v = 16'sd11793;
      7'd16: v = 16'sd12539; 7'd17: v = 16'sd13279; 7'd18: v = 16'sd14010; 7'd19: v = 16'sd14732;
      7'd20: v = 16'sd15446; 7'd21: v = 16'sd16151; 7'd22: v = 16'sd16846; 7'd23: v = 16'sd17530;
      7'd24: v = 16'sd18204; 7'd25: v = 16'sd18868; 7'd26: v = 16'sd19519; 7'd27: v = 16'sd20159;
      7'd28: v = 16'sd20787; 7'd29: v = 16'sd21403; 7'd30: v = 16'sd22005; 7'd31: v = 16'sd22594;
      7'd32: v = 16'sd23170; 7'd33: v = 16'sd23731; 7'd34: v = 16'sd24279; 7'd35: v = 16'sd24811;
      7'd36: v = 16'sd25329; 7'd37: v = 16'sd25832; 7'd38: v = 16'sd26319; 7'd39: v = 16'sd26790;
      7'd40: v = 16'sd27245; 7'd41: v = 16'sd27683; 7'd42: v = 16'sd28105; 7'd43: v = 16'sd28510;
      7'd44: v = 16'sd28898; 7'd45: v = 16'sd29268; 7'd46: v = 16'sd29621; 7'd47: v = 16'sd29956;
      7'd48: v = 16'sd30273; 7'd49: v = 16'sd30571; 7'd50: v = 16'sd30852; 7'd51: v = 16'sd31113;
      7'd52: v = 16'sd31356; 7'd53: v = 16'sd31580; 7'd54: v = 16'sd31785; 7'd55: v = 16'sd31971;
      7'd56: v = 16'sd32137; 7'd57: v = 16'sd32285; 7'd58: v = 16'sd32412; 7'd59: v = 16'sd32521;
      7'd60: v = 16'sd32609; 7'd61: v = 16'sd32678; 7'd62: v = 16'sd32728; 7'd63: v = 16'sd32757;
      7'd64: v = 16'(SIN_AMP);
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

  // Quadrants 1 and 3 read the mirrored index; quadrants 2 and 3 negate.
  function automatic logic signed [LUT_DW-1:0] sine(input logic [LUT_AW-1:0] a);
    logic [6:0]               off;
    logic [6:0]               mir;
    logic signed [LUT_DW-1:0] mag;
    off = {1'b0, a[5:0]};
    mir = 7'd64 - off;
    mag = quarter(a[6] ? mir : off);
    return a[7] ? -mag : mag;
  endfunction

  always_comb begin
    sin_d = sine(sin_addr);
    cos_d = sine(cos_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

endmodule

// File: rtl/qam16_modulator.sv
// Serial bits -> Gray-mapped 16-QAM symbols -> passband sample I*cos - Q*sin.
// Define QAM_PRBS_EN to replace bit_in/bit_valid with an internal PRBS-15 source.
module qam16_modulator
  import qam_pkg::*;
#(
  parameter int          SYM_LEN   = 50,
  parameter logic [31:0] PHASE_INC = 32'd171798692
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic signed [3:0]  i,
  output logic signed [3:0]  q,
  output logic signed [18:0] signal,
  output logic               sym_strobe,
  output logic               sym_underrun,
  output logic               busy
);

  localparam int         DATA_W    = 4;
  localparam int         COEF_W    = LUT_DW;
  localparam int         OUT_W     = 19;
  localparam logic [9:0] SAMP_LAST = 10'(SYM_LEN - 1);

  // |difference| <= 131068 fits 19 bits signed, so plain truncation is exact.
  function automatic logic signed [OUT_W-1:0] mix(
    input logic signed [DATA_W-1:0] li,
    input logic signed [DATA_W-1:0] lq,
    input logic signed [COEF_W-1:0] c,
    input logic signed [COEF_W-1:0] s
  );
    logic signed [19:0] prod_i;
    logic signed [19:0] prod_q;
    logic signed [20:0] diff;
    prod_i = 20'(li) * 20'(c);
    prod_q = 20'(lq) * 20'(s);
    diff   = 21'(prod_i) - 21'(prod_q);
    return diff[OUT_W-1:0];
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  nib_q, nib_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [9:0]  samp_cnt_q, samp_cnt_d;
  logic [31:0] phase_q, phase_d;
  level_t      i_q, i_d, q_q, q_d;
  logic        sym_strobe_q, sym_strobe_d;
  logic        sym_underrun_q, sym_underrun_d;

  level_t                   i_p1_q, i_p1_d, q_p1_q, q_p1_d;
  logic signed [COEF_W-1:0] sin_p1, cos_p1;
  logic signed [OUT_W-1:0]  signal_p2_q, signal_p2_d;
  logic [LUT_AW-1:0]        cos_addr;

  logic src_bit;
  logic src_valid;
  logic accept;
  logic sym_ready;

  assign bit_ready = (nib_cnt_q < 3'd4);
  assign accept    = src_valid && bit_ready;
  assign sym_ready = (nib_cnt_q == 3'd4);

`ifdef QAM_PRBS_EN
  logic [14:0] prbs_q, prbs_d;
  logic        ext_unused;

  assign ext_unused = bit_in ^ bit_valid;
  assign src_bit    = prbs_q[14];
  assign src_valid  = 1'b1;

  always_comb begin
    prbs_d = prbs_q;
    if (accept) prbs_d = {prbs_q[13:0], prbs_q[14] ^ prbs_q[13]};
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) prbs_q <= 15'h7FFF;
    else       prbs_q <= prbs_d;
  end
`else
  assign src_bit   = bit_in;
  assign src_valid = bit_valid;
`endif

  always_comb begin
    state_d        = state_q;
    nib_d          = nib_q;
    nib_cnt_d      = nib_cnt_q;
    samp_cnt_d     = samp_cnt_q;
    phase_d        = phase_q;
    i_d            = i_q;
    q_d            = q_q;
    sym_strobe_d   = 1'b0;
    sym_underrun_d = 1'b0;

    if (accept) begin
      nib_d     = {nib_q[2:0], src_bit};
      nib_cnt_d = nib_cnt_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        i_d        = LVL_ZERO;
        q_d        = LVL_ZERO;
        phase_d    = '0;
        samp_cnt_d = '0;
        if (sym_ready) begin
          i_d          = gray_map(nib_q[3:2]);
          q_d          = gray_map(nib_q[1:0]);
          nib_cnt_d    = '0;
          sym_strobe_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: begin
        phase_d    = phase_q + PHASE_INC;
        samp_cnt_d = samp_cnt_q + 10'd1;
        // Only a nibble complete before the boundary cycle counts for it.
        if (samp_cnt_q == SAMP_LAST) begin
          samp_cnt_d = '0;
          if (sym_ready) begin
            i_d          = gray_map(nib_q[3:2]);
            q_d          = gray_map(nib_q[1:0]);
            nib_cnt_d    = '0;
            sym_strobe_d = 1'b1;
          end else begin
            i_d            = LVL_ZERO;
            q_d            = LVL_ZERO;
            sym_underrun_d = 1'b1;
            state_d        = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      nib_q          <= '0;
      nib_cnt_q      <= '0;
      samp_cnt_q     <= '0;
      phase_q        <= '0;
      i_q            <= LVL_ZERO;
      q_q            <= LVL_ZERO;
      sym_strobe_q   <= 1'b0;
      sym_underrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      nib_q          <= nib_d;
      nib_cnt_q      <= nib_cnt_d;
      samp_cnt_q     <= samp_cnt_d;
      phase_q        <= phase_d;
      i_q            <= i_d;
      q_q            <= q_d;
      sym_strobe_q   <= sym_strobe_d;
      sym_underrun_q <= sym_underrun_d;
    end
  end

  // Stage p1: sine/cosine lookup, levels delayed to stay aligned with it
  assign cos_addr = phase_q[31:24] + 8'd64;

  qam_sin_lut u_lut (
    .clk      (CLOCK_50),
    .rst      (reset),
    .sin_addr (phase_q[31:24]),
    .cos_addr (cos_addr),
    .sin_q    (sin_p1),
    .cos_q    (cos_p1)
  );

  // Stage p2: multiply and subtract
  always_comb begin
    i_p1_d      = i_q;
    q_p1_d      = q_q;
    signal_p2_d = mix(i_p1_q, q_p1_q, cos_p1, sin_p1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      i_p1_q      <= LVL_ZERO;
      q_p1_q      <= LVL_ZERO;
      signal_p2_q <= '0;
    end else begin
      i_p1_q      <= i_p1_d;
      q_p1_q      <= q_p1_d;
      signal_p2_q <= signal_p2_d;
    end
  end

  assign i            = i_q;
  assign q            = q_q;
  assign signal       = signal_p2_q;
  assign sym_strobe   = sym_strobe_q;
  assign sym_underrun = sym_underrun_q;
  assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_qam16_modulator.sv
// Directed self-checking bench for qam16_modulator (SYM_LEN = 50, 2 MHz carrier
// at 50 MHz); compile with QAM_PRBS_EN to exercise the internal PRBS source.
module tb_qam16_modulator;

  logic               CLOCK_50;
  logic               reset;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [3:0]  i;
  logic signed [3:0]  q;
  logic signed [18:0] signal;
  logic               sym_strobe;
  logic               sym_underrun;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe capture filled by the stream task.
  int                st_t  [8];
  logic signed [3:0] st_i  [8];
  logic signed [3:0] st_q  [8];
  logic              st_rb [8];
  logic              st_ra [8];
  int                n_st;
  int                end_t;

  qam16_modulator dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .i            (i),
    .q            (q),
    .signal       (signal),
    .sym_strobe   (sym_strobe),
    .sym_underrun (sym_underrun),
    .busy         (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Feeds nbits (MSB first) with bit_valid held, recording strobes until the first underrun.
  task automatic stream(input logic [15:0] bits, input int nbits);
    int   idx;
    int   guard;
    logic rdy;
    logic prev;
    n_st  = 0;
    end_t = -1;
    idx   = 0;
    guard = 0;
    prev  = bit_ready;
    fork
      begin
        bit_valid = 1'b1;
        while (idx < nbits && guard < 400) begin
          bit_in = bits[nbits-1-idx];
          rdy    = bit_ready;
          tick();
          guard++;
          if (rdy) idx++;
        end
        bit_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 400 && end_t < 0; c++) begin
          tick();
          if (sym_strobe) begin
            if (n_st < 8) begin
              st_t[n_st]  = c;
              st_i[n_st]  = i;
              st_q[n_st]  = q;
              st_rb[n_st] = prev;
              st_ra[n_st] = bit_ready;
            end
            n_st++;
          end
          if (sym_underrun) end_t = c;
          prev = bit_ready;
        end
      end
    join
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (i !== 4'sd0) begin n_fail++; $display("FAIL rst_i: got %0d expected 0", i); end
    n_checks++; if (q !== 4'sd0) begin n_fail++; $display("FAIL rst_q: got %0d expected 0", q); end
    n_checks++; if (signal !== 19'sd0) begin n_fail++; $display("FAIL rst_signal: got %0d expected 0", signal); end
    n_checks++; if (sym_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %b expected 0", sym_strobe); end
    n_checks++; if (sym_underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b expected 0", sym_underrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", bit_ready); end
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

`ifndef QAM_PRBS_EN
  task automatic test_single_symbol();
    int cyc;
    bit ok;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    n_checks++; if (bit_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_full: got %b expected 0", bit_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_pre: got %b expected 0", busy); end
    tick();
    n_checks++; if (sym_strobe !== 1'b1) begin n_fail++; $display("FAIL single_strobe: got %b expected 1", sym_strobe); end
    n_checks++; if (i !== 4'sd1) begin n_fail++; $display("FAIL single_i: got %0d expected 1", i); end
    n_checks++; if (q !== 4'sd2) begin n_fail++; $display("FAIL single_q: got %0d expected 2", q); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    n_checks++; if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after_load: got %b expected 1", bit_ready); end
    tick();
    n_checks++; if (sym_strobe !== 1'b0) begin n_fail++; $display("FAIL single_strobe_pulse: got %b expected 0", sym_strobe); end
    tick();
    n_checks++; if (signal !== 19'sd32767) begin n_fail++; $display("FAIL single_signal_ph0: got %0d expected 32767", signal); end
    tick();
    // phase address 10: cos 31785, sin 7962 -> 31785 - 2*7962
    n_checks++; if (signal !== 19'sd15861) begin n_fail++; $display("FAIL single_signal_ph1: got %0d expected 15861", signal); end
    cyc = 3;
    while (!sym_underrun && cyc < 80) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc !== 50) begin n_fail++; $display("FAIL single_underrun_time: got %0d expected 50", cyc); end
    n_checks++; if (i !== 4'sd0 || q !== 4'sd0) begin n_fail++; $display("FAIL single_iq_zero: got %0d,%0d expected 0,0", i, q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    tick(); tick();
    n_checks++; if (signal !== 19'sd0) begin n_fail++; $display("FAIL single_signal_drain: got %0d expected 0", signal); end
    wait_idle(ok);
  endtask

  task automatic test_continuous();
    logic signed [3:0] ei [4] = '{-4'sd2, -4'sd1, 4'sd2, 4'sd1};
    stream(16'h05AF, 16);
    n_checks++; if (n_st !== 4) begin n_fail++; $display("FAIL cont_count: got %0d expected 4", n_st); end
    for (int k = 0; k < 4 && k < n_st; k++) begin
      n_checks++; if (st_i[k] !== ei[k]) begin n_fail++; $display("FAIL cont_i[%0d]: got %0d expected %0d", k, st_i[k], ei[k]); end
      n_checks++; if (st_q[k] !== ei[k]) begin n_fail++; $display("FAIL cont_q[%0d]: got %0d expected %0d", k, st_q[k], ei[k]); end
      if (k > 0) begin
        n_checks++; if (st_t[k] - st_t[k-1] !== 50) begin n_fail++; $display("FAIL cont_gap[%0d]: got %0d expected 50", k, st_t[k] - st_t[k-1]); end
      end
    end
    n_checks++; if (n_st < 1 || end_t - st_t[(n_st > 0 ? n_st : 1) - 1] !== 50) begin n_fail++; $display("FAIL cont_first_underrun: got cycle %0d expected 50 after last strobe", end_t); end
  endtask

  task automatic test_backpressure();
    logic signed [3:0] ei [3] = '{4'sd1, -4'sd2, 4'sd2};
    logic signed [3:0] eq [3] = '{4'sd2, 4'sd2, -4'sd1};
    stream(16'h0E29, 12);
    n_checks++; if (n_st !== 3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", n_st); end
    for (int k = 0; k < 3 && k < n_st; k++) begin
      n_checks++; if (st_i[k] !== ei[k]) begin n_fail++; $display("FAIL bp_i[%0d]: got %0d expected %0d", k, st_i[k], ei[k]); end
      n_checks++; if (st_q[k] !== eq[k]) begin n_fail++; $display("FAIL bp_q[%0d]: got %0d expected %0d", k, st_q[k], eq[k]); end
      if (k > 0) begin
        n_checks++; if (st_rb[k] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before[%0d]: got %b expected 0", k, st_rb[k]); end
        n_checks++; if (st_ra[k] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after[%0d]: got %b expected 1", k, st_ra[k]); end
      end
    end
    n_checks++; if (end_t < 0) begin n_fail++; $display("FAIL bp_timeout: got no underrun expected one"); end
  endtask

  task automatic test_boundary_bit();
    bit ok;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    tick();
    n_checks++; if (sym_strobe !== 1'b1 || i !== 4'sd1 || q !== -4'sd2) begin n_fail++; $display("FAIL bnd_first: got strobe %b i %0d q %0d expected 1,1,-2", sym_strobe, i, q); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (46) tick();
    n_checks++; if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL bnd_ready: got %b expected 1", bit_ready); end
    send_bit(1'b1);
    n_checks++; if (sym_underrun !== 1'b1) begin n_fail++; $display("FAIL bnd_underrun: got %b expected 1", sym_underrun); end
    n_checks++; if (sym_strobe !== 1'b0) begin n_fail++; $display("FAIL bnd_no_strobe: got %b expected 0", sym_strobe); end
    n_checks++; if (busy !== 1'b0 || i !== 4'sd0) begin n_fail++; $display("FAIL bnd_idle: got busy %b i %0d expected 0,0", busy, i); end
    tick();
    n_checks++; if (sym_strobe !== 1'b1) begin n_fail++; $display("FAIL bnd_late_strobe: got %b expected 1", sym_strobe); end
    n_checks++; if (i !== -4'sd1 || q !== 4'sd1) begin n_fail++; $display("FAIL bnd_late_iq: got %0d,%0d expected -1,1", i, q); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bnd_late_busy: got %b expected 1", busy); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bnd_idle_timeout: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    repeat (11) tick();
    send_bit(1'b1); send_bit(1'b0);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (i !== 4'sd0 || q !== 4'sd0) begin n_fail++; $display("FAIL mid_rst_iq: got %0d,%0d expected 0,0", i, q); end
    n_checks++; if (signal !== 19'sd0) begin n_fail++; $display("FAIL mid_rst_signal: got %0d expected 0", signal); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    n_checks++; if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", bit_ready); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || signal !== 19'sd0) begin n_fail++; $display("FAIL mid_rst_hold: got busy %b signal %0d expected 0,0", busy, signal); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    tick();
    n_checks++; if (sym_strobe !== 1'b1 || i !== -4'sd1 || q !== -4'sd1) begin n_fail++; $display("FAIL mid_rst_fresh: got strobe %b i %0d q %0d expected 1,-1,-1", sym_strobe, i, q); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_rst_idle_timeout: got busy %b expected 0", busy); end
  endtask
`else
  task automatic test_prbs();
    int under;
    n_st  = 0;
    under = 0;
    bit_valid = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (sym_strobe) begin
        if (n_st < 8) begin
          st_t[n_st] = c;
          st_i[n_st] = i;
          st_q[n_st] = q;
        end
        n_st++;
      end
      if (sym_underrun) under++;
    end
    n_checks++; if (n_st < 5) begin n_fail++; $display("FAIL prbs_count: got %0d expected at least 5", n_st); end
    n_checks++; if (st_i[0] !== 4'sd1 || st_q[0] !== 4'sd1) begin n_fail++; $display("FAIL prbs_first: got %0d,%0d expected 1,1", st_i[0], st_q[0]); end
    n_checks++; if (st_i[3] !== 4'sd1 || st_q[3] !== 4'sd2) begin n_fail++; $display("FAIL prbs_fourth: got %0d,%0d expected 1,2", st_i[3], st_q[3]); end
    for (int k = 1; k < 5 && k < n_st; k++) begin
      n_checks++; if (st_t[k] - st_t[k-1] !== 50) begin n_fail++; $display("FAIL prbs_gap[%0d]: got %0d expected 50", k, st_t[k] - st_t[k-1]); end
    end
    n_checks++; if (under !== 0) begin n_fail++; $display("FAIL prbs_underrun: got %0d expected 0", under); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prbs_busy: got %b expected 1", busy); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    test_reset();
`ifndef QAM_PRBS_EN
    test_single_symbol();
    test_continuous();
    test_backpressure();
    test_boundary_bit();
    test_reset_mid_run();
`else
    test_prbs();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qam16_modulator.md
# qam16_modulator

Upstream source for the constellation/oscilloscope display. Accepts a serial bit stream over a valid/ready handshake, groups bits into 4-bit 16-QAM symbols, and Gray-maps each symbol to I/Q levels in {-2,-1,+1,+2}. Holds each symbol for a fixed number of samples and synthesises the passband sample `signal = I·cos − Q·sin` from a phase-accumulator carrier. The display consumes `i`, `q` and `signal` directly.

## Interface
- SYM_LEN, 50: samples per symbol, range 2..1023. The default gives 1 Msym/s at 50 MHz.
- PHASE_INC, 32'd171798692: carrier phase increment per cycle, 2 MHz at 50 MHz.
- CLOCK_50  in  1  system clock, all logic on posedge.
- reset  in  1  **asynchronous, active-high reset**.
- bit_in  in  1  serial data bit, symbol MSB first.
- bit_valid  in  1  `bit_in` is valid.
- bit_ready  out  1  block accepts a bit this cycle.
- i  out  4 signed  current in-phase level.
- q  out  4 signed  current quadrature level.
- signal  out  19 signed  modulated sample.
- sym_strobe  out  1  one-cycle pulse when a new symbol loads into `i`/`q`.
- sym_underrun  out  1  one-cycle pulse when a symbol boundary finds no complete nibble.
- busy  out  1  high in RUN.

## Operation
- Bit acceptance:
  - A bit is accepted when `bit_valid && bit_ready`.
  - Accepted bits shift into a 4-bit nibble register; `nib_cnt` (0..4) increments.
  - `bit_ready = (nib_cnt < 4)`.
- Gray map:
  - Bits b3b2 give I; bits b1b0 give Q.
  - 00→−2, 01→−1, 11→+1, 10→+2.
- States:
  - IDLE:
    - `i = q = 0`, `signal` drains to 0, phase accumulator held at 0.
    - When `nib_cnt == 4`: load the symbol, `nib_cnt ← 0`, pulse `sym_strobe`, start `samp_cnt = 0`, go to RUN.
  - RUN:
    - `samp_cnt` increments each cycle; the phase accumulator adds PHASE_INC each cycle (wraps mod 2^32).
    - At `samp_cnt == SYM_LEN−1` (boundary):
      - If `nib_cnt == 4`: load the next symbol, clear `nib_cnt`, pulse `sym_strobe`, `samp_cnt ← 0`, stay in RUN.
      - Otherwise: pulse `sym_underrun`, `i = q = 0`, go to IDLE.
- Simultaneous events:
  - A bit accepted on the boundary cycle that would make `nib_cnt` 4 does **not** count for that boundary; underrun occurs.
  - The bit is still accepted and the nibble completes. IDLE then loads it on the next cycle.
- Carrier:
  - Top 8 bits of the phase address a 256-entry signed 16-bit sine table, amplitude 32767.
  - cos uses address + 64 (mod 256).
- Arithmetic:
  - Products are 4-bit × 16-bit signed, 20 bits each.
  - Difference magnitude ≤ 131068; assign to the 19-bit `signal` without saturation.
- Reset values:
  - `bit_ready = 1`.
  - `i`, `q`, `signal`, `sym_strobe`, `sym_underrun`, `busy` = 0.
  - State IDLE; `nib_cnt`, `samp_cnt`, phase = 0.
  - Reset mid-symbol discards the partial nibble and the current symbol immediately.

## Timing
- Bit accept → `nib_cnt` update: next edge.
- In IDLE with `nib_cnt == 4`: `i`/`q`/`sym_strobe`/`busy` update on the following edge.
- Symbol period: exactly SYM_LEN cycles between `sym_strobe` pulses when fed continuously.
- `signal` pipeline: LUT register (1) + multiply/subtract register (1). `signal` lags `i`/`q`/phase by 2 cycles.
- After IDLE entry, `signal` reaches 0 within 2 cycles.

## Configuration
- QAM_PRBS_EN defined:
  - An internal PRBS-15 source (x^15+x^14+1, seed 15'h7FFF at reset) replaces `bit_in`/`bit_valid`.
  - It advances only on accepted bits; effective valid is always 1.
  - `bit_in` and `bit_valid` are ignored.
- QAM_PRBS_EN undefined: external handshake only; no PRBS logic.

## Structure
- Package `qam_pkg`:
  - level typedef (signed [3:0]);
  - Gray-map constants;
  - state enum (IDLE, RUN);
  - sine amplitude and LUT depth constants.
- Sub-module `qam_sin_lut`: 256×16 signed registered ROM with two read ports (sin, cos), one-cycle latency.

## Test plan
- Reset mid-RUN → all outputs 0 and `bit_ready = 1` on the next edge; `signal` 0.
- Feed 1,1,1,0 then stop → one `sym_strobe`, `i = +1`, `q = +2`, `signal = +32767` two cycles after the strobe. After SYM_LEN cycles: `sym_underrun` pulse, `i = q = 0`, `busy = 0`.
- Continuous nibbles 0000, 0101, 1010, 1111 → (i,q) = (−2,−2), (−1,−1), (+2,+2), (+1,+1). Strobes exactly 50 cycles apart; no underrun.
- Hold `bit_valid` with an idle symbol slot → `bit_ready` drops after the 4th bit, rises the cycle after the symbol load; no bits lost (check mapped sequence).
- 4th bit arrives on the boundary cycle → `sym_underrun` that cycle; the new symbol loads one cycle later with `sym_strobe`.
- QAM_PRBS_EN defined → first symbol (b3..b0 = 1111) gives `i = q = +1`; strobes every SYM_LEN cycles indefinitely; no underrun.
